// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N:1 streaming multiplexer with an internal round-robin /
// fixed-priority arbiter feeding a one-entry output register that also
// records which channel supplied the held beat.
//
// Handshake rules (all channels): a beat moves across an interface on a rising
// clock edge where valid and ready are both 1. A producer keeps valid high and
// its data stable until that happens. ready may depend combinationally on
// valid, and in_ready depends combinationally on out_ready because there is no
// skid buffer. At most one in_ready bit is high, and it is only ever high for
// a channel whose in_valid is high.
module stream_mux_rr #(
  parameter  int N_CH  = 4,
  parameter  int W     = 4,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic [N_CH-1:0]     in_valid,
  input  logic [N_CH*W-1:0]   in_data,
  output logic [N_CH-1:0]     in_ready,
  output logic                out_valid,
  output logic [W-1:0]        out_data,
  output logic [SEL_W-1:0]    out_sel,
  input  logic                out_ready
);

  // Channel that won the previous transfer; the round-robin scan starts after it.
  logic [SEL_W-1:0] last_grant;
  logic [SEL_W-1:0] grant;
  logic [SEL_W-1:0] scan_idx;
  logic             found;
  logic             slot_free;
  logic             xfer;
  logic [W-1:0]     grant_data;

  // Arbiter: scan channels in priority order and keep the first valid one.
  // Mode 1 scans from index 0; mode 0 starts one past the last winner and wraps.
  always_comb begin
    grant    = '0;
    found    = 1'b0;
    scan_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      scan_idx = mode ? SEL_W'(k) : SEL_W'((int'(last_grant) + 1 + k) % N_CH);
      if (!found && in_valid[scan_idx]) begin
        grant = scan_idx;
        found = 1'b1;
      end
    end
  end

  // The output register can take a new beat when it is empty or draining now.
  always_comb begin
    slot_free = !out_valid || out_ready;
    xfer      = rst && slot_free && found;
  end

  // Ready goes only to the granted channel, and never while reset is asserted.
  always_comb begin
    in_ready = '0;
    if (xfer) begin
      in_ready[grant] = 1'b1;
    end
  end

  // Only the granted lane's data is routed, so other lanes never reach the outputs.
  always_comb begin
    grant_data = in_data[int'(grant)*W +: W];
  end

  // Output register: load on transfer, clear on drain, hold on stall.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_sel    <= '0;
      last_grant <= SEL_W'(N_CH - 1);
    end else if (xfer) begin
      out_valid  <= 1'b1;
      out_data   <= grant_data;
      out_sel    <= grant;
      last_grant <= grant;
    end else if (out_valid && out_ready) begin
      out_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: directed scenarios with literal expectations, then a long
// randomized run. A queue-based model of the output slot is compared with the
// DUT on every falling clock edge.
module tb_stream_mux_rr;

  localparam int N_CH  = 4;
  localparam int W     = 4;
  localparam int SEL_W = $clog2(N_CH);
  localparam int DW    = N_CH * W;

  logic             clk;
  logic             rst;
  logic             mode;
  logic [N_CH-1:0]  in_valid;
  logic [DW-1:0]    in_data;
  logic [N_CH-1:0]  in_ready;
  logic             out_valid;
  logic [W-1:0]     out_data;
  logic [SEL_W-1:0] out_sel;
  logic             out_ready;

  int n_checks = 0;
  int n_fail   = 0;
  logic chk_en;

  stream_mux_rr #(.N_CH(N_CH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The output slot is a queue of at most one {sel, data} beat.
  logic [SEL_W+W-1:0] exp_q[$];
  int m_last;
  int m_g;
  bit m_slot;

  // Winner from the arbitration rules; -1 when nobody is valid.
  function automatic int exp_grant(input logic [N_CH-1:0] v, input logic m, input int last);
    if (v == '0) return -1;
    if (m) begin
      for (int i = 0; i < N_CH; i++) if (v[i]) return i;
    end else begin
      for (int step = 1; step <= N_CH; step++) begin
        int c;
        c = (last + step) % N_CH;
        if (v[c]) return c;
      end
    end
    return -1;
  endfunction

  // Advance the model on each rising edge using the inputs held during the cycle.
  always @(posedge clk) begin
    if (!rst) begin
      exp_q.delete();
      m_last = N_CH - 1;
    end else begin
      m_g    = exp_grant(in_valid, mode, m_last);
      m_slot = (exp_q.size() == 0) || out_ready;
      if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      if (m_slot && m_g >= 0) begin
        exp_q.push_back({SEL_W'(m_g), in_data[m_g*W +: W]});
        m_last = m_g;
      end
    end
  end

  // Compare DUT against model on every falling edge.
  logic [N_CH-1:0] cmp_ready;
  int cmp_g;
  always @(negedge clk) begin
    if (chk_en) begin
      cmp_ready = '0;
      cmp_g = exp_grant(in_valid, mode, m_last);
      if (rst && (exp_q.size() == 0 || out_ready) && cmp_g >= 0) cmp_ready[cmp_g] = 1'b1;
      chk("model in_ready", 32'(in_ready), 32'(cmp_ready));
      chk("model out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("model out_data", 32'(out_data), 32'(exp_q[0][W-1:0]));
        chk("model out_sel", 32'(out_sel), 32'(exp_q[0][W +: SEL_W]));
      end
    end
  end

  // ---------------- driver helpers ----------------
  // Inputs change 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; mode = 1'b0; in_valid = '0; in_data = '0; out_ready = 1'b0;
    chk_en = 1'b0;
    tick();
    chk_en = 1'b1;

    // Reset held with every channel valid.
    in_valid = '1; in_data = DW'($urandom); out_ready = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("reset out_valid", 32'(out_valid), 0);
    chk("reset out_data", 32'(out_data), 0);
    chk("reset out_sel", 32'(out_sel), 0);
    chk("reset in_ready", 32'(in_ready), 0);
    tick();

    // Round-robin with everyone valid: 0,1,2,3,0 at one beat per cycle.
    rst = 1'b1; mode = 1'b0; in_valid = 4'b1111; in_data = 16'hDCBA; out_ready = 1'b1;
    @(negedge clk);
    chk("rr first ready", 32'(in_ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clk);
      chk("rr out_valid", 32'(out_valid), 1);
      chk("rr out_sel", 32'(out_sel), 32'(k % 4));
      chk("rr out_data", 32'(out_data), 32'(10 + k % 4));
    end
    tick();

    // Fixed priority with channels 1 and 3: channel 1 always wins.
    mode = 1'b1; in_valid = 4'b1010;
    repeat (4) begin
      tick();
      @(negedge clk);
      chk("fixed in_ready", 32'(in_ready), 32'h2);
      chk("fixed out_sel", 32'(out_sel), 1);
      chk("fixed out_data", 32'(out_data), 32'hB);
    end
    tick();

    // Back-pressure after the first beat; last winner is channel 1.
    mode = 1'b0; in_valid = 4'b1111;
    @(negedge clk);
    chk("bp first ready", 32'(in_ready), 32'h4);
    tick();
    out_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall out_valid", 32'(out_valid), 1);
      chk("stall out_sel", 32'(out_sel), 2);
      chk("stall out_data", 32'(out_data), 32'hC);
      chk("stall in_ready", 32'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release in_ready", 32'(in_ready), 32'h8);
    tick();

    // Sparse and wrapping: only ch2 after ch3, then ch0+ch2 after ch2.
    in_valid = 4'b0100;
    @(negedge clk);
    chk("release out_sel", 32'(out_sel), 3);
    chk("release out_data", 32'(out_data), 32'hD);
    chk("sparse in_ready", 32'(in_ready), 32'h4);
    tick();
    in_valid = 4'b0101;
    @(negedge clk);
    chk("sparse out_sel", 32'(out_sel), 2);
    chk("wrap in_ready", 32'(in_ready), 32'h1);
    tick();

    // Reset while a beat is stalled: the beat is dropped, arbitration restarts at ch0.
    out_ready = 1'b0; in_valid = 4'b1111;
    @(negedge clk);
    chk("wrap out_sel", 32'(out_sel), 0);
    chk("wrap out_data", 32'(out_data), 32'hA);
    chk("held out_valid", 32'(out_valid), 1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 0);
    chk("pre-rst out_valid", 32'(out_valid), 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst out_valid", 32'(out_valid), 0);
    chk("post-rst in_ready", 32'(in_ready), 32'h1);
    tick();
    @(negedge clk);
    chk("post-rst out_sel", 32'(out_sel), 0);
    chk("post-rst out_valid2", 32'(out_valid), 1);
    tick();

    // Randomized traffic with occasional resets and mode flips.
    repeat (3000) begin
      rst       = ($urandom_range(0, 99) != 0);
      mode      = ($urandom_range(0, 3) == 0);
      in_valid  = N_CH'($urandom);
      in_data   = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
